id_ex_stage: RTL and testbench
==============================

// Module: id_ex_stage
// PURPOSE
//  ID/EX pipeline register plus EX-side operand forwarding and load-use hazard detection.
//  Captures one decoded instruction per cycle from ID and drives the ALU inputs (A, B, ALUOp, PC).
//  It also drives the EX/MEM-bound control and store data.
//  Handles flush (taken branch/jump), load-use bubble insertion and global hold.
// PARAMETERS
//  XLEN      32  datapath width (A/B/PC/imm)
//  RIDX      5   register index width
//  NOP_OP    5'b00000  ALUOp value driven for bubbles/reset (`ALUOp_nop)
// PORTS
//  clk            in   1     rising-edge clock
//  rstn           in   1     asynchronous active-low reset
//  hold_i         in   1     global freeze (memory wait); register keeps contents
//  flush_i        in   1     kill instruction entering EX (branch/jump resolved taken)
//  id_valid       in   1     ID holds a real instruction
//  id_pc          in   XLEN  PC of ID instruction
//  id_rs1,id_rs2  in   RIDX  source register indices
//  id_rd          in   RIDX  destination index
//  id_rd1,id_rd2  in   XLEN  register-file read data
//  id_imm         in   XLEN  sign-extended immediate
//  id_aluop       in   5     ALU operation code
//  id_alusrc      in   1     1: B=imm, 0: B=rs2 value
//  id_regwrite    in   1     writes rd
//  id_memread     in   1     load
//  id_memwrite    in   1     store
//  id_wdsel       in   2     writeback select (passed through)
//  exmem_regwrite in   1     EX/MEM instruction writes rd
//  exmem_rd       in   RIDX  EX/MEM destination
//  exmem_aluout   in   XLEN  EX/MEM ALU result
//  memwb_regwrite in   1     MEM/WB instruction writes rd
//  memwb_rd       in   RIDX  MEM/WB destination
//  memwb_wd       in   XLEN  MEM/WB writeback data
//  ex_A, ex_B     out  XLEN  forwarded ALU operands
//  ex_aluop       out  5     registered ALUOp
//  ex_pc          out  XLEN  registered PC (for auipc/branch target)
//  ex_store_data  out  XLEN  forwarded rs2 value for stores
//  ex_rd          out  RIDX  registered destination
//  ex_regwrite, ex_memread, ex_memwrite  out 1  registered controls
//  ex_wdsel       out  2     registered writeback select
//  ex_valid       out  1     EX holds a real instruction
//  load_use_stall out  1     to IF/ID: hold PC and IF/ID this cycle
// BEHAVIOUR
//  - Reset (rstn=0, async): every registered field 0, ex_aluop=NOP_OP, ex_valid=0; outputs follow.
//  - Update priority each posedge: flush_i > hold_i > load_use_stall > capture.
//    flush: load bubble. hold: keep all. load_use_stall: load bubble. else capture all id_* fields.
//  - Bubble: valid/regwrite/memread/memwrite=0, rd=0, aluop=NOP_OP; pc/data fields don't-care (drive 0).
//  - Capture latency 1 cycle; id_valid=0 captured as bubble.
//  - load_use_stall (comb) = ex_valid & ex_memread & ex_rd!=0 & id_valid & (ex_rd==id_rs1 | ex_rd==id_rs2).
//    Suppressed (0) while flush_i=1; under hold_i it still asserts but has no effect.
//  - Forwarding (comb, per source rsX of EX instruction, registered rs1/rs2 indices):
//    rsX==0 -> 0; else exmem_regwrite & exmem_rd==rsX -> exmem_aluout;
//    else memwb_regwrite & memwb_rd==rsX -> memwb_wd; else registered rdX. EX/MEM beats MEM/WB.
//  - ex_A = fwd(rs1); ex_B = alusrc ? imm : fwd(rs2); ex_store_data = fwd(rs2) always.
//  - No arithmetic here; widths pass through unchanged. x0 never forwarded even if a producer names it.
//  - Reset mid-stall: stall drops immediately since ex_valid=0.
// TESTING
//  1 Reset: rstn=0 async mid-cycle -> ex_valid=0, ex_aluop=0, ex_A=ex_B=0 without clock edge.
//  2 Capture: id add x3,x1,x2 rd1=5 rd2=7, no fwd -> next cycle ex_A=5, ex_B=7, ex_rd=3, ex_valid=1.
//  3 Forward priority: EX rs1=x4, exmem_rd=4 aluout=0x11, memwb_rd=4 wd=0x22 -> ex_A=0x11; exmem_regwrite=0 -> 0x22.
//  4 Load-use: EX lw x5 (memread), ID rs2=x5 -> load_use_stall=1, next cycle bubble, following cycle ID add captured.
//  5 Flush vs hold: flush_i=1 with hold_i=1 -> bubble loaded; hold_i alone 3 cycles -> outputs unchanged.
//  6 x0: EX rs1=0, exmem_rd=0 regwrite=1 aluout=0xFF -> ex_A=0; alusrc=1 imm=0xFFFFFFF0 -> ex_B=0xFFFFFFF0.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX-side operand forwarding and load-use hazard detection.
// Bubbles are inserted on flush, load-use stall or an idle ID slot; hold freezes the stage.
module id_ex_stage #(
  parameter int         XLEN   = 32,
  parameter int         RIDX   = 5,
  parameter logic [4:0] NOP_OP = 5'b00000
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            hold_i,
  input  logic            flush_i,
  input  logic            id_valid,
  input  logic [XLEN-1:0] id_pc,
  input  logic [RIDX-1:0] id_rs1,
  input  logic [RIDX-1:0] id_rs2,
  input  logic [RIDX-1:0] id_rd,
  input  logic [XLEN-1:0] id_rd1,
  input  logic [XLEN-1:0] id_rd2,
  input  logic [XLEN-1:0] id_imm,
  input  logic [4:0]      id_aluop,
  input  logic            id_alusrc,
  input  logic            id_regwrite,
  input  logic            id_memread,
  input  logic            id_memwrite,
  input  logic [1:0]      id_wdsel,
  input  logic            exmem_regwrite,
  input  logic [RIDX-1:0] exmem_rd,
  input  logic [XLEN-1:0] exmem_aluout,
  input  logic            memwb_regwrite,
  input  logic [RIDX-1:0] memwb_rd,
  input  logic [XLEN-1:0] memwb_wd,
  output logic [XLEN-1:0] ex_A,
  output logic [XLEN-1:0] ex_B,
  output logic [4:0]      ex_aluop,
  output logic [XLEN-1:0] ex_pc,
  output logic [XLEN-1:0] ex_store_data,
  output logic [RIDX-1:0] ex_rd,
  output logic            ex_regwrite,
  output logic            ex_memread,
  output logic            ex_memwrite,
  output logic [1:0]      ex_wdsel,
  output logic            ex_valid,
  output logic            load_use_stall
);

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [RIDX-1:0] rs1;
    logic [RIDX-1:0] rs2;
    logic [RIDX-1:0] rd;
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    logic [XLEN-1:0] imm;
    logic [4:0]      aluop;
    logic            alusrc;
    logic            regwrite;
    logic            memread;
    logic            memwrite;
    logic [1:0]      wdsel;
  } stage_t;

  stage_t          stage_r;
  stage_t          stage_nxt_s;
  stage_t          capture_s;
  logic            load_use_s;
  logic [XLEN-1:0] fwd_rs1_s;
  logic [XLEN-1:0] fwd_rs2_s;

  function automatic stage_t bubble_f();
    stage_t b;
    b       = '0;
    b.aluop = NOP_OP;
    return b;
  endfunction

  // x0 is hard-wired zero, so a producer naming it must never be forwarded.
  function automatic logic [XLEN-1:0] fwd_f(
    input logic [RIDX-1:0] rs,
    input logic [XLEN-1:0] regval,
    input logic            em_rw,
    input logic [RIDX-1:0] em_rd,
    input logic [XLEN-1:0] em_val,
    input logic            mw_rw,
    input logic [RIDX-1:0] mw_rd,
    input logic [XLEN-1:0] mw_val
  );
    logic [XLEN-1:0] r;
    if (rs == {RIDX{1'b0}}) begin
      r = {XLEN{1'b0}};
    end else if (em_rw && (em_rd == rs)) begin
      r = em_val;
    end else if (mw_rw && (mw_rd == rs)) begin
      r = mw_val;
    end else begin
      r = regval;
    end
    return r;
  endfunction

  // Pack the incoming ID fields into a stage record.
  always_comb begin
    capture_s          = '0;
    capture_s.valid    = 1'b1;
    capture_s.pc       = id_pc;
    capture_s.rs1      = id_rs1;
    capture_s.rs2      = id_rs2;
    capture_s.rd       = id_rd;
    capture_s.rd1      = id_rd1;
    capture_s.rd2      = id_rd2;
    capture_s.imm      = id_imm;
    capture_s.aluop    = id_aluop;
    capture_s.alusrc   = id_alusrc;
    capture_s.regwrite = id_regwrite;
    capture_s.memread  = id_memread;
    capture_s.memwrite = id_memwrite;
    capture_s.wdsel    = id_wdsel;
  end

  // Load in EX whose result is needed by ID; a flush makes the ID instruction irrelevant.
  always_comb begin
    load_use_s = 1'b0;
    if (!flush_i && stage_r.valid && stage_r.memread && (stage_r.rd != {RIDX{1'b0}}) &&
        id_valid && ((stage_r.rd == id_rs1) || (stage_r.rd == id_rs2))) begin
      load_use_s = 1'b1;
    end else begin
      load_use_s = 1'b0;
    end
  end

  // Next-state selection: flush beats hold, hold beats stall, stall beats capture.
  always_comb begin
    stage_nxt_s = stage_r;
    if (flush_i) begin
      stage_nxt_s = bubble_f();
    end else if (hold_i) begin
      stage_nxt_s = stage_r;
    end else if (load_use_s || !id_valid) begin
      stage_nxt_s = bubble_f();
    end else begin
      stage_nxt_s = capture_s;
    end
  end

  // Pipeline register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stage_r <= bubble_f();
    end else begin
      stage_r <= stage_nxt_s;
    end
  end

  // Operand forwarding for both EX sources.
  always_comb begin
    fwd_rs1_s = fwd_f(stage_r.rs1, stage_r.rd1, exmem_regwrite, exmem_rd, exmem_aluout,
                      memwb_regwrite, memwb_rd, memwb_wd);
    fwd_rs2_s = fwd_f(stage_r.rs2, stage_r.rd2, exmem_regwrite, exmem_rd, exmem_aluout,
                      memwb_regwrite, memwb_rd, memwb_wd);
  end

  assign ex_A           = fwd_rs1_s;
  assign ex_B           = stage_r.alusrc ? stage_r.imm : fwd_rs2_s;
  assign ex_store_data  = fwd_rs2_s;
  assign ex_aluop       = stage_r.aluop;
  assign ex_pc          = stage_r.pc;
  assign ex_rd          = stage_r.rd;
  assign ex_regwrite    = stage_r.regwrite;
  assign ex_memread     = stage_r.memread;
  assign ex_memwrite    = stage_r.memwrite;
  assign ex_wdsel       = stage_r.wdsel;
  assign ex_valid       = stage_r.valid;
  assign load_use_stall = load_use_s;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: stimulus queues expected EX outputs per cycle,
// a negedge monitor pops and compares them.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rstn, hold_i, flush_i, id_valid;
  logic [31:0] id_pc, id_rd1, id_rd2, id_imm;
  logic [4:0]  id_rs1, id_rs2, id_rd, id_aluop;
  logic        id_alusrc, id_regwrite, id_memread, id_memwrite;
  logic [1:0]  id_wdsel;
  logic        exmem_regwrite, memwb_regwrite;
  logic [4:0]  exmem_rd, memwb_rd;
  logic [31:0] exmem_aluout, memwb_wd;
  logic [31:0] ex_A, ex_B, ex_pc, ex_store_data;
  logic [4:0]  ex_aluop, ex_rd;
  logic        ex_regwrite, ex_memread, ex_memwrite, ex_valid, load_use_stall;
  logic [1:0]  ex_wdsel;

  typedef struct packed {
    logic        valid;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  aluop;
    logic [4:0]  rd;
    logic        rw;
    logic        mr;
    logic        mw;
    logic [1:0]  ws;
    logic [31:0] sd;
    logic [31:0] pc;
    logic        stall;
  } obs_t;

  typedef struct {
    int    cyc;
    string name;
    obs_t  exp;
  } sb_t;

  sb_t sbq[$];
  int  cyc = 0;
  int  n_chk = 0;
  int  n_fail = 0;

  id_ex_stage dut (
    .clk(clk), .rstn(rstn), .hold_i(hold_i), .flush_i(flush_i),
    .id_valid(id_valid), .id_pc(id_pc), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm), .id_aluop(id_aluop),
    .id_alusrc(id_alusrc), .id_regwrite(id_regwrite), .id_memread(id_memread),
    .id_memwrite(id_memwrite), .id_wdsel(id_wdsel),
    .exmem_regwrite(exmem_regwrite), .exmem_rd(exmem_rd), .exmem_aluout(exmem_aluout),
    .memwb_regwrite(memwb_regwrite), .memwb_rd(memwb_rd), .memwb_wd(memwb_wd),
    .ex_A(ex_A), .ex_B(ex_B), .ex_aluop(ex_aluop), .ex_pc(ex_pc),
    .ex_store_data(ex_store_data), .ex_rd(ex_rd), .ex_regwrite(ex_regwrite),
    .ex_memread(ex_memread), .ex_memwrite(ex_memwrite), .ex_wdsel(ex_wdsel),
    .ex_valid(ex_valid), .load_use_stall(load_use_stall)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compare everything due this cycle against the live outputs.
  always @(negedge clk) begin
    sb_t  t;
    obs_t act;
    act = {ex_valid, ex_A, ex_B, ex_aluop, ex_rd, ex_regwrite, ex_memread, ex_memwrite,
           ex_wdsel, ex_store_data, ex_pc, load_use_stall};
    while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
      t = sbq.pop_front();
      n_chk++;
      if (t.cyc != cyc) begin
        n_fail++;
        $display("FAIL %s: check missed (due cycle %0d, now %0d)", t.name, t.cyc, cyc);
      end else if (act !== t.exp) begin
        n_fail++;
        $display("FAIL %s: got v=%0b A=%h B=%h op=%0d rd=%0d rw/mr/mw=%0b%0b%0b ws=%0d sd=%h pc=%h stall=%0b, expected v=%0b A=%h B=%h op=%0d rd=%0d rw/mr/mw=%0b%0b%0b ws=%0d sd=%h pc=%h stall=%0b",
                 t.name, act.valid, act.a, act.b, act.aluop, act.rd, act.rw, act.mr, act.mw,
                 act.ws, act.sd, act.pc, act.stall, t.exp.valid, t.exp.a, t.exp.b, t.exp.aluop,
                 t.exp.rd, t.exp.rw, t.exp.mr, t.exp.mw, t.exp.ws, t.exp.sd, t.exp.pc, t.exp.stall);
      end
    end
  end

  function automatic obs_t mk(input logic v, input logic [31:0] a, input logic [31:0] b,
                              input logic [4:0] op, input logic [4:0] rd, input logic rw,
                              input logic mr, input logic mw, input logic [1:0] ws,
                              input logic [31:0] sd, input logic [31:0] pc, input logic st);
    obs_t o;
    o = {v, a, b, op, rd, rw, mr, mw, ws, sd, pc, st};
    return o;
  endfunction

  function automatic obs_t bub();
    return mk(1'b0, 32'h0, 32'h0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0, 1'b0);
  endfunction

  task automatic chk(input string nm, input obs_t e);
    sb_t t;
    t.cyc  = cyc;
    t.name = nm;
    t.exp  = e;
    sbq.push_back(t);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_valid = 1'b0; id_pc = 32'h0; id_rs1 = 5'd0; id_rs2 = 5'd0; id_rd = 5'd0;
    id_rd1 = 32'h0; id_rd2 = 32'h0; id_imm = 32'h0; id_aluop = 5'd0; id_alusrc = 1'b0;
    id_regwrite = 1'b0; id_memread = 1'b0; id_memwrite = 1'b0; id_wdsel = 2'd0;
  endtask

  task automatic inst(input logic [31:0] pc, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic [4:0] rd, input logic [31:0] r1, input logic [31:0] r2,
                      input logic [31:0] imm, input logic [4:0] op, input logic asrc,
                      input logic rw, input logic mr, input logic mw, input logic [1:0] ws);
    id_valid = 1'b1; id_pc = pc; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
    id_rd1 = r1; id_rd2 = r2; id_imm = imm; id_aluop = op; id_alusrc = asrc;
    id_regwrite = rw; id_memread = mr; id_memwrite = mw; id_wdsel = ws;
  endtask

  initial begin
    obs_t held;
    rstn = 1'b0; hold_i = 1'b0; flush_i = 1'b0;
    idle();
    exmem_regwrite = 1'b0; exmem_rd = 5'd0; exmem_aluout = 32'h0;
    memwb_regwrite = 1'b0; memwb_rd = 5'd0; memwb_wd = 32'h0;
    repeat (2) step();
    rstn = 1'b1;
    chk("reset_state", bub());

    // Plain capture: add x3,x1,x2
    step(); inst(32'h1000, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 32'h0, 5'd1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd1);
    step(); idle();
    chk("capture_add", mk(1'b1, 32'd5, 32'd7, 5'd1, 5'd3, 1'b1, 1'b0, 1'b0, 2'd1, 32'd7, 32'h1000, 1'b0));

    // Forwarding priority on rs1=x4, stage held so the same EX instruction is observed
    step(); inst(32'h1004, 5'd4, 5'd0, 5'd6, 32'hAAAA, 32'h0, 32'h0, 5'd2, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0);
    step(); idle(); hold_i = 1'b1;
    exmem_regwrite = 1'b1; exmem_rd = 5'd4; exmem_aluout = 32'h11;
    memwb_regwrite = 1'b1; memwb_rd = 5'd4; memwb_wd = 32'h22;
    chk("fwd_exmem", mk(1'b1, 32'h11, 32'h0, 5'd2, 5'd6, 1'b1, 1'b0, 1'b0, 2'd0, 32'h0, 32'h1004, 1'b0));
    step(); exmem_regwrite = 1'b0;
    chk("fwd_memwb", mk(1'b1, 32'h22, 32'h0, 5'd2, 5'd6, 1'b1, 1'b0, 1'b0, 2'd0, 32'h0, 32'h1004, 1'b0));
    step(); memwb_regwrite = 1'b0; hold_i = 1'b0;
    chk("fwd_none", mk(1'b1, 32'hAAAA, 32'h0, 5'd2, 5'd6, 1'b1, 1'b0, 1'b0, 2'd0, 32'h0, 32'h1004, 1'b0));

    // x0 never forwarded; immediate selected for B
    step(); inst(32'h1008, 5'd0, 5'd0, 5'd7, 32'h1234, 32'h5678, 32'hFFFFFFF0, 5'd3, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0);
    chk("idle_bubble", bub());
    step(); idle();
    exmem_regwrite = 1'b1; exmem_rd = 5'd0; exmem_aluout = 32'hFF;
    memwb_regwrite = 1'b1; memwb_rd = 5'd0; memwb_wd = 32'hEE;
    chk("x0_fwd", mk(1'b1, 32'h0, 32'hFFFFFFF0, 5'd3, 5'd7, 1'b1, 1'b0, 1'b0, 2'd0, 32'h0, 32'h1008, 1'b0));

    // Load-use: lw x5 in EX, add x8,x6,x5 in ID
    step(); exmem_regwrite = 1'b0; memwb_regwrite = 1'b0; exmem_aluout = 32'h0; memwb_wd = 32'h0;
    inst(32'h100C, 5'd1, 5'd0, 5'd5, 32'h100, 32'h0, 32'd8, 5'd4, 1'b1, 1'b1, 1'b1, 1'b0, 2'd2);
    step(); inst(32'h1010, 5'd6, 5'd5, 5'd8, 32'd3, 32'd9, 32'h0, 5'd1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0);
    chk("lu_stall", mk(1'b1, 32'h100, 32'd8, 5'd4, 5'd5, 1'b1, 1'b1, 1'b0, 2'd2, 32'h0, 32'h100C, 1'b1));
    step(); memwb_regwrite = 1'b1; memwb_rd = 5'd5; memwb_wd = 32'h55;
    chk("lu_bubble", bub());
    step(); idle();
    chk("lu_capture", mk(1'b1, 32'd3, 32'h55, 5'd1, 5'd8, 1'b1, 1'b0, 1'b0, 2'd0, 32'h55, 32'h1010, 1'b0));

    // Flush beats hold, then hold freezes for three cycles
    step(); memwb_regwrite = 1'b0; memwb_rd = 5'd0; memwb_wd = 32'h0;
    inst(32'h1014, 5'd2, 5'd0, 5'd9, 32'h77, 32'h0, 32'h0, 5'd5, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0);
    step(); inst(32'h1018, 5'd3, 5'd0, 5'd10, 32'h88, 32'h0, 32'h0, 5'd6, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0);
    flush_i = 1'b1; hold_i = 1'b1;
    chk("pre_flush", mk(1'b1, 32'h77, 32'h0, 5'd5, 5'd9, 1'b1, 1'b0, 1'b0, 2'd0, 32'h0, 32'h1014, 1'b0));
    step(); flush_i = 1'b0; hold_i = 1'b0;
    chk("flush_over_hold", bub());
    step(); inst(32'h101C, 5'd4, 5'd0, 5'd11, 32'h99, 32'h0, 32'h0, 5'd7, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0);
    hold_i = 1'b1;
    held = mk(1'b1, 32'h88, 32'h0, 5'd6, 5'd10, 1'b1, 1'b0, 1'b0, 2'd0, 32'h0, 32'h1018, 1'b0);
    chk("capture_after_flush", held);
    for (int i = 1; i <= 3; i++) begin
      step();
      chk($sformatf("hold_%0d", i), held);
      if (i == 3) hold_i = 1'b0;
    end
    step(); idle();
    chk("hold_release_capture", mk(1'b1, 32'h99, 32'h0, 5'd7, 5'd11, 1'b1, 1'b0, 1'b0, 2'd0, 32'h0, 32'h101C, 1'b0));

    // Flush suppresses a load-use stall
    step(); inst(32'h1020, 5'd1, 5'd0, 5'd5, 32'h200, 32'h0, 32'd4, 5'd4, 1'b1, 1'b1, 1'b1, 1'b0, 2'd2);
    step(); inst(32'h1024, 5'd5, 5'd0, 5'd12, 32'd1, 32'h0, 32'h0, 5'd1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0);
    flush_i = 1'b1;
    chk("flush_kills_stall", mk(1'b1, 32'h200, 32'd4, 5'd4, 5'd5, 1'b1, 1'b1, 1'b0, 2'd2, 32'h0, 32'h1020, 1'b0));
    step(); flush_i = 1'b0; idle();
    chk("flush_bubble", bub());

    // Asynchronous reset mid-cycle while a load-use hazard is present
    step(); inst(32'h1028, 5'd1, 5'd0, 5'd5, 32'h300, 32'h0, 32'd4, 5'd4, 1'b1, 1'b1, 1'b1, 1'b0, 2'd2);
    step(); inst(32'h102C, 5'd6, 5'd5, 5'd13, 32'd1, 32'd2, 32'h0, 5'd1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0);
    rstn = 1'b0;
    chk("async_reset", bub());
    step(); idle(); rstn = 1'b1;
    chk("post_reset", bub());

    for (int k = 0; k < 10 && sbq.size() > 0; k++) @(negedge clk);
    #1;
    while (sbq.size() > 0) begin
      sb_t t;
      t = sbq.pop_front();
      n_chk++;
      n_fail++;
      $display("FAIL %s: never compared (due cycle %0d)", t.name, t.cyc);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
